// File: rtl/pipe_arbiter2_pkg.sv
// Shared types for the two-port pipeconnect arbiter.
//
// req_t : master -> slave request (A, R, W, WD, WBE).
// res_t : slave -> master response (stall = the pipeconnect WAIT line, RD).
//         WAIT is a reserved word in SystemVerilog, hence the field name
//         'stall'.
// owner_e : owner encoding (NONE=0, P0=1, P1=2), 2 bits, reusable by wider
//           arbiters built on the same port types.
package pipe_arbiter2_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WBE_W  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic              r;
    logic              w;
    logic [DATA_W-1:0] wd;
    logic [WBE_W-1:0]  wbe;
  } req_t;

  typedef struct packed {
    logic              stall;
    logic [DATA_W-1:0] rd;
  } res_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  // A port is requesting when it asserts either R or W.
  function automatic logic is_active(input req_t q);
    return q.r | q.w;
  endfunction

endpackage

// File: rtl/pipe_arbiter2.sv
// Two-port priority arbiter sharing one pipeconnect memory port.
//
// Port 0 (framebuffer scanout) wins by default. A saturating streak counter
// of port-0 accepts made while port 1 waits bounds port-1 starvation: once
// it reaches STREAK_MAX the next grant goes to port 1. A stalled request
// locks ownership until it is accepted, so the owner never changes
// mid-transaction. Read data is routed back only to the port whose read was
// accepted on the previous cycle.
//
// Handshake (every port): a master holds its request stable while WAIT
// (res.stall) is high; a slave raises WAIT only while R or W is high; a
// request is accepted on a cycle with R|W high and WAIT low; read data
// appears on RD exactly one cycle after a read is accepted.
//
// Ports:
//   clk25MHz    system/memory clock
//   rst         synchronous active-high reset
//   p0_req/res  port 0 (scanout) request in, response out
//   p1_req/res  port 1 (CPU/DMA) request in, response out
//   mem_req     request towards the memory controller
//   mem_res     response from the memory controller
//   p1_starved  one-cycle registered pulse on a streak-forced port-1 grant
module pipe_arbiter2
  import pipe_arbiter2_pkg::*;
#(
  parameter int STREAK_MAX = 8,
  parameter int STREAK_W   = 4
) (
  input  logic clk25MHz,
  input  logic rst,
  input  req_t p0_req,
  output res_t p0_res,
  input  req_t p1_req,
  output res_t p1_res,
  output req_t mem_req,
  input  res_t mem_res,
  output logic p1_starved
);

  localparam logic [STREAK_W-1:0] STREAK_TOP = STREAK_W'(STREAK_MAX);

  logic                act0;
  logic                act1;
  owner_e              sel;
  logic                locked;
  owner_e              lock_owner;
  owner_e              rd_owner;
  logic [STREAK_W-1:0] streak;
  logic                mem_active;
  logic                stalled;
  logic                accepted;

  assign act0 = is_active(p0_req);
  assign act1 = is_active(p1_req);

  // Owner selection. Reset forces NONE so mem_req is all-zero during rst.
  always_comb begin
    sel = OWN_NONE;
    if (rst) begin
      sel = OWN_NONE;
    end else if (locked) begin
      sel = lock_owner;
    end else if (act0 && act1) begin
      sel = (streak == STREAK_TOP) ? OWN_P1 : OWN_P0;
    end else if (act0) begin
      sel = OWN_P0;
    end else if (act1) begin
      sel = OWN_P1;
    end
  end

  // Request mux: zero-cycle path from the selected port to memory.
  always_comb begin
    mem_req = '0;
    case (sel)
      OWN_P0:  mem_req = p0_req;
      OWN_P1:  mem_req = p1_req;
      default: mem_req = '0;
    endcase
  end

  assign mem_active = is_active(mem_req);
  assign stalled    = mem_active & mem_res.stall;
  assign accepted   = mem_active & ~mem_res.stall;

  // Responses. A requesting port that does not own the memory port is held
  // off with WAIT=1; an idle port always sees WAIT=0. RD is steered by the
  // registered read owner, so a new accept and a read return can coexist.
  always_comb begin
    p0_res       = '0;
    p1_res       = '0;
    p0_res.stall = (sel == OWN_P0) ? mem_res.stall : act0;
    p1_res.stall = (sel == OWN_P1) ? mem_res.stall : act1;
    p0_res.rd    = (rd_owner == OWN_P0) ? mem_res.rd : '0;
    p1_res.rd    = (rd_owner == OWN_P1) ? mem_res.rd : '0;
  end

  always_ff @(posedge clk25MHz) begin
    if (rst) begin
      locked     <= 1'b0;
      lock_owner <= OWN_NONE;
      rd_owner   <= OWN_NONE;
      streak     <= '0;
      p1_starved <= 1'b0;
    end else begin
      if (stalled) begin
        locked     <= 1'b1;
        lock_owner <= sel;
      end else if (accepted) begin
        locked     <= 1'b0;
        lock_owner <= OWN_NONE;
      end

      rd_owner <= (mem_req.r && !mem_res.stall) ? sel : OWN_NONE;

      // The pulse uses the streak value that forced the grant.
      p1_starved <= accepted && (sel == OWN_P1) && (streak == STREAK_TOP);

      // Streak moves only on accepted transfers and saturates at the top.
      if (accepted) begin
        if ((sel == OWN_P0) && act1) begin
          if (streak != STREAK_TOP) begin
            streak <= streak + 1'b1;
          end
        end else begin
          streak <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_arbiter2.sv
module tb_pipe_arbiter2;
  import pipe_arbiter2_pkg::*;

  localparam int          SMAX = 8;
  localparam logic [31:0] A0   = 32'h0000_0100;
  localparam logic [31:0] A1   = 32'h0000_0200;

  // ---------------- clock / reset ----------------
  logic clk25MHz = 1'b0;
  logic rst;
  always #20 clk25MHz = ~clk25MHz;

  req_t p0_req, p1_req, mem_req;
  res_t p0_res, p1_res, mem_res;
  logic p1_starved;

  pipe_arbiter2 #(.STREAK_MAX(SMAX), .STREAK_W(4)) dut (
    .clk25MHz  (clk25MHz),
    .rst       (rst),
    .p0_req    (p0_req),
    .p0_res    (p0_res),
    .p1_req    (p1_req),
    .p1_res    (p1_res),
    .mem_req   (mem_req),
    .mem_res   (mem_res),
    .p1_starved(p1_starved)
  );

  // ---------------- scoreboard counters ----------------
  int total  = 0;
  int passed = 0;

  // Behavioural reference state: who holds the port after a stall, how many
  // port-0 wins port 1 has sat through, who gets next cycle's read data.
  int m_lock   = 0;
  int m_streak = 0;
  int m_rd_to  = 0;
  bit m_starve = 1'b0;

  // Observations from the last step, used by the hand-written sequences and
  // by the random masters to obey the hold-while-WAIT rule.
  req_t obs_mem;
  res_t obs_r0, obs_r1;
  logic obs_st;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic req_t mk(input logic [31:0] a, input logic r, input logic w);
    req_t q;
    q.a   = a;
    q.r   = r;
    q.w   = w;
    q.wd  = w ? (a ^ 32'hA5A5_0000) : 32'h0;
    q.wbe = w ? 4'hF : 4'h0;
    return q;
  endfunction

  function automatic req_t rand_req();
    req_t q;
    int   kind;
    kind  = $urandom_range(0, 2);
    q.a   = 32'($urandom_range(0, 255)) << 2;
    q.r   = (kind == 1);
    q.w   = (kind == 2);
    q.wd  = $urandom;
    q.wbe = 4'($urandom_range(0, 15));
    return q;
  endfunction

  // ---------------- driver + model check, one clock per call ----------------
  // Called at a negedge; drives, checks #1 later, updates the model at the
  // posedge and returns at the following negedge.
  task automatic step(input req_t r0, input req_t r1, input logic st,
                      input logic [31:0] d, input logic rs);
    bit   want0, want1, acc;
    int   owner;
    req_t exp_mem;
    logic [31:0] exp_rd0, exp_rd1;
    rst           = rs;
    p0_req        = r0;
    p1_req        = r1;
    mem_res.stall = st;
    mem_res.rd    = d;
    #1;
    want0 = r0.r | r0.w;
    want1 = r1.r | r1.w;
    if (rs)                   owner = 0;
    else if (m_lock != 0)     owner = m_lock;
    else if (want0 && want1)  owner = (m_streak >= SMAX) ? 2 : 1;
    else if (want0)           owner = 1;
    else if (want1)           owner = 2;
    else                      owner = 0;
    exp_mem = (owner == 1) ? r0 : (owner == 2) ? r1 : '0;
    check("mem_req", 80'(mem_req), 80'(exp_mem));
    if (!rs) begin
      check("p0_wait", 80'(p0_res.stall), 80'((owner == 1) ? st : want0));
      check("p1_wait", 80'(p1_res.stall), 80'((owner == 2) ? st : want1));
    end
    exp_rd0 = (m_rd_to == 1) ? d : 32'h0;
    exp_rd1 = (m_rd_to == 2) ? d : 32'h0;
    check("p0_rd", 80'(p0_res.rd), 80'(exp_rd0));
    check("p1_rd", 80'(p1_res.rd), 80'(exp_rd1));
    check("p1_starved", 80'(p1_starved), 80'(m_starve));
    obs_mem = mem_req;
    obs_r0  = p0_res;
    obs_r1  = p1_res;
    obs_st  = p1_starved;
    @(posedge clk25MHz);
    if (rs) begin
      m_lock = 0; m_streak = 0; m_rd_to = 0; m_starve = 1'b0;
    end else begin
      acc      = (owner != 0) && !st;
      m_lock   = (owner != 0 && st) ? owner : 0;
      m_rd_to  = (acc && exp_mem.r) ? owner : 0;
      m_starve = acc && (owner == 2) && (m_streak == SMAX);
      if (acc) m_streak = (owner == 1 && want1) ? ((m_streak + 1 > SMAX) ? SMAX : m_streak + 1) : 0;
    end
    @(negedge clk25MHz);
  endtask

  task automatic do_reset();
    step('0, '0, 1'b0, 32'h0, 1'b1);
  endtask

  // Both ports keep requesting until port 1 is granted; returns how many
  // port-0 grants came first (bounded).
  task automatic count_p0_first(input logic st_unused, output int n);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      step(mk(A0, 1, 0), mk(A1, 1, 0), 1'b0, $urandom, 1'b0);
      if (obs_mem.a == A1) break;
      n++;
    end
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic p0r, p0w, p1r, p1w, st;
    int   src;
    logic w0, w1;
  } vec_t;
  vec_t tbl[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   n;
    req_t c0, c1;
    logic [31:0] dv[3];

    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 0, 1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1, 1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1, 1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 2, 1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 2, 1'b0,1'b0};
    tbl[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1, 1'b0,1'b1};
    tbl[6]  = '{1'b0,1'b1,1'b0,1'b1,1'b0, 1, 1'b0,1'b1};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1, 1'b1,1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b1, 2, 1'b0,1'b1};
    tbl[9]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1, 1'b1,1'b1};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 0, 1'b0,1'b0};

    rst     = 1'b1;
    p0_req  = '0;
    p1_req  = '0;
    mem_res = '0;
    repeat (2) @(posedge clk25MHz);
    @(negedge clk25MHz);

    // Reset state: idle ports, everything zero.
    step('0, '0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    check("reset_mem_req", 80'(obs_mem), 80'(0));
    check("reset_starved", 80'(obs_st), 80'(0));

    // Single-cycle arbitration vectors from a fresh state.
    for (int i = 0; i < 11; i++) begin
      do_reset();
      step(mk(A0, tbl[i].p0r, tbl[i].p0w), mk(A1, tbl[i].p1r, tbl[i].p1w),
           tbl[i].st, 32'h1234_0000 + 32'(i), 1'b0);
      check("tbl_src", 80'(obs_mem.a),
            80'((tbl[i].src == 1) ? A0 : (tbl[i].src == 2) ? A1 : 32'h0));
      check("tbl_w0", 80'(obs_r0.stall), 80'(tbl[i].w0));
      check("tbl_w1", 80'(obs_r1.stall), 80'(tbl[i].w1));
    end

    // Port 0 only: back-to-back reads, data one cycle later, none to port 1.
    do_reset();
    dv[0] = 32'h1111_0001; dv[1] = 32'h2222_0002; dv[2] = 32'h3333_0003;
    for (int i = 0; i < 3; i++) begin
      step(mk(A0 + 32'(4 * i), 1, 0), '0, 1'b0, (i == 0) ? 32'h0 : dv[i-1], 1'b0);
      check("p0seq_addr", 80'(obs_mem.a), 80'(A0 + 32'(4 * i)));
      if (i > 0) check("p0seq_rd", 80'(obs_r0.rd), 80'(dv[i-1]));
    end
    step('0, '0, 1'b0, dv[2], 1'b0);
    check("p0seq_rd_last", 80'(obs_r0.rd), 80'(dv[2]));
    check("p0seq_p1_rd", 80'(obs_r1.rd), 80'(0));

    // Continuous contention: 8 x P0 then 1 x P1, starved pulse after each P1.
    do_reset();
    for (int i = 0; i < 27; i++) begin
      step(mk(A0, 1, 0), mk(A1, 1, 0), 1'b0, $urandom, 1'b0);
      check("grant_pattern", 80'(obs_mem.a), 80'(((i % 9) == 8) ? A1 : A0));
      check("starve_pulse", 80'(obs_st), 80'((i > 0) && ((i % 9) == 0)));
    end

    // Port 1 write stalled 5 cycles; port 0 joins and must wait.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step((i >= 2) ? mk(A0, 1, 0) : '0, mk(A1, 0, 1), 1'b1, 32'h0, 1'b0);
      check("lock_addr", 80'(obs_mem.a), 80'(A1));
      check("lock_write", 80'(obs_mem.w), 80'(1));
      if (i >= 2) check("lock_p0_wait", 80'(obs_r0.stall), 80'(1));
    end
    step(mk(A0, 1, 0), mk(A1, 0, 1), 1'b0, 32'h0, 1'b0);
    check("write_accept_addr", 80'(obs_mem.a), 80'(A1));
    step(mk(A0, 1, 0), '0, 1'b0, 32'h0, 1'b0);
    check("p0_after_write", 80'(obs_mem.a), 80'(A0));

    // P0 read at n, P1 read at n+1: data routed strictly per owner.
    do_reset();
    step(mk(A0, 1, 0), '0, 1'b0, 32'h0, 1'b0);
    step('0, mk(A1, 1, 0), 1'b0, 32'hAAAA_0000, 1'b0);
    check("ovl_rd0_n1", 80'(obs_r0.rd), 80'(32'hAAAA_0000));
    check("ovl_rd1_n1", 80'(obs_r1.rd), 80'(0));
    step('0, '0, 1'b0, 32'hBBBB_0000, 1'b0);
    check("ovl_rd1_n2", 80'(obs_r1.rd), 80'(32'hBBBB_0000));
    check("ovl_rd0_n2", 80'(obs_r0.rd), 80'(0));

    // Reset while locked with a partly grown streak.
    do_reset();
    for (int i = 0; i < 5; i++) step(mk(A0, 1, 0), mk(A1, 1, 0), 1'b0, 32'h0, 1'b0);
    step(mk(A0, 1, 0), mk(A1, 1, 0), 1'b1, 32'h0, 1'b0);
    step(mk(A0, 1, 0), mk(A1, 1, 0), 1'b1, 32'h0, 1'b1);
    check("rst_mem_req", 80'(obs_mem), 80'(0));
    step('0, '0, 1'b0, 32'hCAFE_F00D, 1'b0);
    check("rst_late_rd0", 80'(obs_r0.rd), 80'(0));
    check("rst_late_rd1", 80'(obs_r1.rd), 80'(0));
    count_p0_first(1'b0, n);
    check("rst_streak_cleared", 80'(n), 80'(SMAX));

    // Port 1 idle through 20 port-0 accepts: streak must not build up.
    do_reset();
    for (int i = 0; i < 20; i++) step(mk(A0 + 32'(4 * i), 1, 0), '0, 1'b0, 32'h0, 1'b0);
    count_p0_first(1'b0, n);
    check("idle_p1_streak", 80'(n), 80'(SMAX));
    step('0, mk(A1, 0, 1), 1'b0, 32'h0, 1'b0);
    check("p1_alone_granted", 80'(obs_mem.a), 80'(A1));

    // Randomized traffic against the reference model.
    do_reset();
    c0 = '0;
    c1 = '0;
    for (int i = 0; i < 600; i++) begin
      if (!obs_r0.stall) c0 = rand_req();
      if (!obs_r1.stall) c1 = rand_req();
      step(c0, c1, ($urandom_range(0, 9) < 3), $urandom, ($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_arbiter2.md
# pipe_arbiter2

Two-port priority arbiter sharing one pipeconnect memory port between the framebuffer scanout master (port 0, the VGA FIFO filler) and a general master (port 1, CPU/DMA). Sits between both masters and the SRAM controller. Port 0 wins by default, but a streak counter bounds port 1 starvation. Read data is returned only to the port whose read was accepted.

## Interface
Parameters:
- `STREAK_MAX`, default 8: max consecutive port-0 grants while port 1 is pending; the next free slot goes to port 1.
- `STREAK_W`, default 4: streak counter width; must hold `STREAK_MAX`.

Ports:
- `clk25MHz`  in  1  system/memory clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `p0_req`  in  `REQ`  port 0 request (A, R, W, WD, WBE).
- `p0_res`  out  `RES`  port 0 response (WAIT, RD).
- `p1_req`  in  `REQ`  port 1 request.
- `p1_res`  out  `RES`  port 1 response.
- `mem_req`  out  `REQ`  request to the memory controller.
- `mem_res`  in  `RES`  response from the memory controller.
- `p1_starved`  out  1  registered; pulses one cycle when a streak-forced port-1 grant occurs (debug/perf counter).

## Operation
- Pipeconnect rules apply on every port:
  - A master holds A/R/W/WD/WBE stable while WAIT is high.
  - A slave raises WAIT only when R or W is high.
  - Read data appears on RD exactly one cycle after the read is accepted. Accepted means R & ~WAIT.
- Port `pN` is requesting when `pN_req`R | `pN_req`W`.
- Select: `sel` is a combinational choice of owner, one of NONE, P0 or P1.
  - If `locked` is set, `sel = lock_owner`.
  - Else if both ports request: P1 when `streak == STREAK_MAX`, otherwise P0.
  - Else the single requesting port; NONE when nothing requests.
- `mem_req` = the selected port's req. All fields are zero when `sel` = NONE or `rst` = 1.
- WAIT to the selected port = `mem_res`WAIT`. WAIT to a requesting, non-selected port = 1. WAIT to an idle port = 0.
- Lock: when the selected request is stalled (`mem_res`WAIT` = 1), set `locked <= 1`, `lock_owner <= sel`.
  - The lock clears on the first cycle the request is accepted.
  - An owner is never switched mid-transaction.
- Read return: `rd_owner <= sel` when `mem_req`R & ~mem_res`WAIT`, else NONE.
  - `pN_res`RD` = `mem_res`RD` when `rd_owner == PN`, else 0.
- Streak counter, updated on acceptance only:
  - P0 accepted while port 1 is requesting: `streak <= min(streak+1, STREAK_MAX)`.
  - P1 accepted, or port 1 idle: `streak <= 0`.
- `p1_starved <= 1` for one cycle when P1 is accepted with `streak == STREAK_MAX`.
- Simultaneous events:
  - A new accept in the same cycle as a read return is legal. The `rd_owner` update and the RD routing use the old and new value without conflict.
  - A port withdrawing its request is only legal when its WAIT = 0. The arbiter does not check this.
- Reset mid-transaction:
  - `locked`, `lock_owner`, `rd_owner` and `streak` are cleared; `p1_starved` = 0.
  - Any read data arriving in the cycle after reset is dropped, since RD is 0 to both ports.

## Timing
- Zero-cycle request path: `pN_req` to `mem_req` is combinational (mux only). `mem_res`WAIT` to `pN_res`WAIT` is combinational.
- Read latency seen by a master: 1 cycle after its acceptance, identical to direct connection.
- Reset values:
  - `locked` = 0, `lock_owner` = NONE, `rd_owner` = NONE, `streak` = 0, `p1_starved` = 0.
  - `mem_req` = 0 while `rst`.
- Back-to-back accepts from either port and port switching every cycle are both supported with no bubble.

## Structure
- Owner encoding (NONE=0, P0=1, P1=2; 2 bits) goes as defines in `pipeconnect.h` next to the existing `REQ`/`RES` field macros, for reuse by wider arbiters.
- No sub-module: select mux, lock register, `rd_owner` pipe and streak counter all live in one module.

## Test plan
- Port 0 only, reads at A=0x100,0x104,0x108 with memory WAIT=0: three accepts in three cycles. `p0_res`RD` carries the data one cycle after each. `p1_res`RD` = 0.
- Both ports request continuously with `STREAK_MAX`=8: the grant pattern is 8×P0, 1×P1 repeating. `p1_starved` pulses on each P1 grant.
- Port 1 holds a write and memory WAIT=1 for 5 cycles while port 0 starts requesting: `mem_req` stays on port 1 for all 5 cycles. `p0_res`WAIT`=1. Port 0 is granted the cycle after the write is accepted.
- P0 read accepted at cycle n, P1 read accepted at cycle n+1: RD at n+1 goes only to port 0, RD at n+2 only to port 1.
- `rst` asserted while `locked` with a pending port-0 read: the next cycle shows `mem_req`=0 and `streak`=0, the late RD is delivered to neither port, and normal arbitration resumes after `rst` falls.
- Port 1 idle for 20 cycles of port-0 traffic: `streak` stays 0. A later single port-1 request is granted only when port 0 is idle, or after 8 port-0 accepts while port 1 waits.
